// File: rtl/fifo_uart_pkg.sv
// Shared types and frame constants for the FIFO-fed 8N1 serial transmitter.
package fifo_uart_pkg;

  localparam int DATA_BITS = 8;
  localparam int BIT_CNT_W = $clog2(DATA_BITS);

  localparam logic START_LEVEL = 1'b0;
  localparam logic STOP_LEVEL  = 1'b1;
  localparam logic IDLE_LEVEL  = 1'b1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    POP   = 3'd1,
    LOAD  = 3'd2,
    START = 3'd3,
    DATA  = 3'd4,
    STOP  = 3'd5
  } tx_state_e;

  typedef logic [DATA_BITS-1:0] byte_t;

  // Bit timing only runs while a frame is on the line.
  function automatic logic on_line(input tx_state_e s);
    return (s == START) || (s == DATA) || (s == STOP);
  endfunction

endpackage

// File: rtl/fifo_uart_tx_baud.sv
// Bit-period counter: one-cycle tick on the last clock of every bit.
module baud_tick_gen #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  output logic tick_o
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (clear_i || (cnt_q == CNT_MAX)) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = !clear_i && (cnt_q == CNT_MAX);

endmodule

// File: rtl/fifo_uart_tx.sv
// Pops one byte per frame from the byte FIFO and shifts it out as 8N1.
module fifo_uart_tx
  import fifo_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_enable,
  input  logic        in_fifo_is_empty,
  input  logic [7:0]  in_fifo_read_data,
  output logic        out_fifo_read_ctrl,
  output logic        out_tx,
  output logic        out_busy,
  output logic        out_frame_done
);

  localparam logic [BIT_CNT_W-1:0] LAST_BIT =
    BIT_CNT_W'(DATA_BITS - 1);

  tx_state_e state_q;
  tx_state_e state_d;
  byte_t     shift_q;
  byte_t     shift_d;
  logic [BIT_CNT_W-1:0] bit_q;
  logic [BIT_CNT_W-1:0] bit_d;

  logic tick;
  logic baud_clear;

  // Held clear outside the frame so START always begins at count 0.
  assign baud_clear = !on_line(state_q);

  baud_tick_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk    (clk),
    .rst    (rst),
    .clear_i(baud_clear),
    .tick_o (tick)
  );

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bit_d   = bit_q;
    unique case (state_q)
      IDLE: begin
        if (in_enable && !in_fifo_is_empty) begin
          state_d = POP;
        end
      end
      POP: begin
        state_d = LOAD;
      end
      LOAD: begin
        shift_d = in_fifo_read_data;
        bit_d   = '0;
        state_d = START;
      end
      START: begin
        if (tick) begin
          state_d = DATA;
        end
      end
      DATA: begin
        if (tick) begin
          shift_d = shift_q >> 1;
          if (bit_q == LAST_BIT) begin
            bit_d   = '0;
            state_d = STOP;
          end else begin
            bit_d = bit_q + BIT_CNT_W'(1);
          end
        end
      end
      STOP: begin
        if (tick) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      shift_q <= '0;
      bit_q   <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
    end
  end

  always_comb begin
    out_tx = IDLE_LEVEL;
    unique case (state_q)
      START:   out_tx = START_LEVEL;
      DATA:    out_tx = shift_q[0];
      STOP:    out_tx = STOP_LEVEL;
      default: out_tx = IDLE_LEVEL;
    endcase
  end

  assign out_fifo_read_ctrl = (state_q == POP);
  assign out_busy           = (state_q != IDLE);
  assign out_frame_done     = (state_q == STOP) && tick;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: FIFO model, line logger and an 8N1 receiver model.
module tb_fifo_uart_tx;
  import fifo_uart_pkg::*;

  localparam int CPB   = 4;
  localparam int FRAME = 10 * CPB;
  localparam int LOGN  = 4096;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b0;
  logic       empty_q = 1'b1;
  logic [7:0] rdata_q = 8'h00;
  logic       rd;
  logic       tx;
  logic       busy;
  logic       done;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  fifo_uart_tx #(
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .in_enable         (en),
    .in_fifo_is_empty  (empty_q),
    .in_fifo_read_data (rdata_q),
    .out_fifo_read_ctrl(rd),
    .out_tx            (tx),
    .out_busy          (busy),
    .out_frame_done    (done)
  );

  // Byte FIFO: registered empty flag, one-cycle read latency.
  logic [7:0] fifo_mem [64];
  int wr_ptr = 0;
  int rd_ptr = 0;

  always @(posedge clk) begin
    if (rd && (rd_ptr != wr_ptr)) begin
      rdata_q <= fifo_mem[rd_ptr % 64];
      rd_ptr  <= rd_ptr + 1;
      empty_q <= ((rd_ptr + 1) == wr_ptr);
    end else begin
      empty_q <= (rd_ptr == wr_ptr);
    end
  end

  task automatic push(input logic [7:0] b);
    fifo_mem[wr_ptr % 64] = b;
    wr_ptr = wr_ptr + 1;
  endtask

  // One sample of every output per cycle, taken on the falling edge.
  logic lg_tx   [LOGN];
  logic lg_rd   [LOGN];
  logic lg_busy [LOGN];
  logic lg_done [LOGN];
  int   lg_n = 0;

  always @(negedge clk) begin
    if (lg_n < LOGN) begin
      lg_tx[lg_n]   <= tx;
      lg_rd[lg_n]   <= rd;
      lg_busy[lg_n] <= busy;
      lg_done[lg_n] <= done;
    end
    lg_n <= lg_n + 1;
  end

  cov_idle:  cover property (@(posedge clk) dut.state_q == IDLE);
  cov_pop:   cover property (@(posedge clk) dut.state_q == POP);
  cov_load:  cover property (@(posedge clk) dut.state_q == LOAD);
  cov_start: cover property (@(posedge clk) dut.state_q == START);
  cov_data:  cover property (@(posedge clk) dut.state_q == DATA);
  cov_stop:  cover property (@(posedge clk) dut.state_q == STOP);
  cov_done:  cover property (@(posedge clk) done);

  // Expected line level k cycles into a frame carrying byte b.
  function automatic logic exp_level(input logic [7:0] b, input int k);
    logic [9:0] f;
    f = {STOP_LEVEL, b, START_LEVEL};
    return f[k / CPB];
  endfunction

  function automatic int wave_errs(input int s, input logic [7:0] b);
    int e = 0;
    for (int k = 0; k < FRAME; k++) begin
      if (lg_tx[s + k] !== exp_level(b, k)) e++;
    end
    return e;
  endfunction

  // which: 0 read strobes, 1 frame_done, 2 busy, 3 line-low cycles
  function automatic int count(input int which, input int from, input int to);
    int c = 0;
    for (int i = from; i < to; i++) begin
      if (which == 0 && lg_rd[i] === 1'b1) c++;
      if (which == 1 && lg_done[i] === 1'b1) c++;
      if (which == 2 && lg_busy[i] === 1'b1) c++;
      if (which == 3 && lg_tx[i] === 1'b0) c++;
    end
    return c;
  endfunction

  function automatic int first_low(input int from, input int to);
    for (int i = from; i < to; i++) begin
      if (lg_tx[i] === 1'b0) return i;
    end
    return -1;
  endfunction

  task automatic test_reset();
    int base;
    en  = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    tests++;
    if (tx !== 1'b1 || busy !== 1'b0 || rd !== 1'b0 || done !== 1'b0) begin
      fails++;
      $display("FAIL reset_held: tx=%b busy=%b rd=%b done=%b want 1 0 0 0",
               tx, busy, rd, done);
    end
    #1 rst = 1'b0;
    #1;
    tests++;
    if (tx !== 1'b1 || busy !== 1'b0 || rd !== 1'b0 || done !== 1'b0) begin
      fails++;
      $display("FAIL reset_release: tx=%b busy=%b rd=%b done=%b want 1 0 0 0",
               tx, busy, rd, done);
    end
    @(negedge clk);
    en   = 1'b1;
    base = lg_n;
    repeat (100) @(negedge clk);
    #1;
    tests++;
    if (count(0, base, lg_n) !== 0 || count(3, base, lg_n) !== 0 ||
        count(2, base, lg_n) !== 0) begin
      fails++;
      $display("FAIL reset_quiet: reads=%0d low=%0d busy=%0d want 0 0 0",
               count(0, base, lg_n), count(3, base, lg_n), count(2, base, lg_n));
    end
  endtask

  task automatic test_empty();
    int base;
    @(negedge clk);
    en   = 1'b1;
    base = lg_n;
    repeat (200) @(negedge clk);
    #1;
    tests++;
    if (count(0, base, lg_n) !== 0) begin
      fails++;
      $display("FAIL empty_reads: got %0d want 0", count(0, base, lg_n));
    end
    tests++;
    if (count(3, base, lg_n) !== 0) begin
      fails++;
      $display("FAIL empty_line: low cycles %0d want 0", count(3, base, lg_n));
    end
  endtask

  task automatic test_single();
    int base;
    int s;
    @(negedge clk);
    en = 1'b1;
    push(8'hA5);
    base = lg_n;
    repeat (60) @(negedge clk);
    #1;
    s = first_low(base, lg_n);
    tests++;
    if (s !== base + 4) begin
      fails++;
      $display("FAIL single_latency: start at +%0d want +4", s - base);
    end
    if (s < base + 3 || s + 41 > lg_n) return;
    tests++;
    if (count(0, base, lg_n) !== 1 || lg_rd[s - 2] !== 1'b1) begin
      fails++;
      $display("FAIL single_read: reads=%0d rd@pop=%b want 1 1",
               count(0, base, lg_n), lg_rd[s - 2]);
    end
    tests++;
    if (wave_errs(s, 8'hA5) !== 0) begin
      fails++;
      $display("FAIL single_wave: %0d bad cycles want 0", wave_errs(s, 8'hA5));
    end
    tests++;
    if (count(1, base, lg_n) !== 1 || lg_done[s + FRAME - 1] !== 1'b1) begin
      fails++;
      $display("FAIL single_done: pulses=%0d at_end=%b want 1 1",
               count(1, base, lg_n), lg_done[s + FRAME - 1]);
    end
    tests++;
    if (count(2, s - 2, s + FRAME) !== FRAME + 2 ||
        lg_busy[s - 3] !== 1'b0 || lg_busy[s + FRAME] !== 1'b0) begin
      fails++;
      $display("FAIL single_busy: in=%0d pre=%b post=%b want %0d 0 0",
               count(2, s - 2, s + FRAME), lg_busy[s - 3],
               lg_busy[s + FRAME], FRAME + 2);
    end
  endtask

  task automatic test_back_to_back();
    int base;
    int s1;
    int s2;
    @(negedge clk);
    en = 1'b1;
    push(8'h00);
    push(8'hFF);
    base = lg_n;
    repeat (110) @(negedge clk);
    #1;
    s1 = first_low(base, lg_n);
    s2 = (s1 < 0) ? -1 : first_low(s1 + FRAME, lg_n);
    tests++;
    if (s1 < 0 || s2 !== s1 + FRAME + 3) begin
      fails++;
      $display("FAIL b2b_gap: second start %0d after first want %0d",
               s2 - s1, FRAME + 3);
    end
    if (s1 < 0 || s2 < 0 || s2 + FRAME > lg_n) return;
    tests++;
    if (wave_errs(s1, 8'h00) !== 0 || count(3, s1 + FRAME, s2) !== 0) begin
      fails++;
      $display("FAIL b2b_first: bad=%0d gap_low=%0d want 0 0",
               wave_errs(s1, 8'h00), count(3, s1 + FRAME, s2));
    end
    tests++;
    if (wave_errs(s2, 8'hFF) !== 0 || count(3, s2 + CPB, s2 + 9 * CPB) !== 0) begin
      fails++;
      $display("FAIL b2b_second: bad=%0d data_low=%0d want 0 0",
               wave_errs(s2, 8'hFF), count(3, s2 + CPB, s2 + 9 * CPB));
    end
    tests++;
    if (count(0, base, lg_n) !== 2 || count(1, base, lg_n) !== 2) begin
      fails++;
      $display("FAIL b2b_counts: reads=%0d done=%0d want 2 2",
               count(0, base, lg_n), count(1, base, lg_n));
    end
  endtask

  task automatic test_enable_gating();
    int base;
    int s;
    logic [7:0] b0;
    logic [7:0] b1;
    b0 = 8'($urandom);
    b1 = 8'($urandom);
    @(negedge clk);
    en = 1'b1;
    push(b0);
    push(b1);
    base = lg_n;
    repeat (21) @(negedge clk);
    en = 1'b0;
    repeat (79) @(negedge clk);
    #1;
    s = first_low(base, lg_n);
    tests++;
    if (s < 0 || s + FRAME > lg_n || wave_errs(s, b0) !== 0) begin
      fails++;
      $display("FAIL gate_frame: start=%0d byte=%h frame incomplete or wrong",
               s - base, b0);
    end
    tests++;
    if (count(0, base, lg_n) !== 1 || count(1, base, lg_n) !== 1) begin
      fails++;
      $display("FAIL gate_counts: reads=%0d done=%0d want 1 1",
               count(0, base, lg_n), count(1, base, lg_n));
    end
    tests++;
    if (s >= 0 && (count(3, s + FRAME, lg_n) !== 0 || lg_busy[lg_n - 1] !== 1'b0)) begin
      fails++;
      $display("FAIL gate_idle: low=%0d busy=%b want 0 0",
               count(3, s + FRAME, lg_n), lg_busy[lg_n - 1]);
    end
    @(negedge clk);
    en   = 1'b1;
    base = lg_n;
    repeat (60) @(negedge clk);
    #1;
    s = first_low(base, lg_n);
    tests++;
    if (s < base + 3 || s + FRAME > lg_n || lg_rd[s - 2] !== 1'b1 ||
        lg_busy[s - 3] !== 1'b0 || wave_errs(s, b1) !== 0) begin
      fails++;
      $display("FAIL gate_resume: start=%0d byte=%h want start +3 and clean frame",
               s - base, b1);
    end
    tests++;
    if (count(0, base, lg_n) !== 1) begin
      fails++;
      $display("FAIL gate_resume_reads: got %0d want 1", count(0, base, lg_n));
    end
  endtask

  task automatic test_reset_midframe();
    int base;
    int s;
    @(negedge clk);
    en = 1'b1;
    push(8'h3C);
    push(8'h81);
    base = lg_n;
    repeat (29) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    tests++;
    if (lg_busy[base + 28] !== 1'b1 || tx !== 1'b1 || busy !== 1'b0 || rd !== 1'b0) begin
      fails++;
      $display("FAIL rst_mid: busy_before=%b tx=%b busy=%b rd=%b want 1 1 0 0",
               lg_busy[base + 28], tx, busy, rd);
    end
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    base = lg_n;
    repeat (70) @(negedge clk);
    #1;
    s = first_low(base, lg_n);
    tests++;
    if (s < 0 || s + FRAME > lg_n || wave_errs(s, 8'h81) !== 0) begin
      fails++;
      $display("FAIL rst_next_byte: start=%0d want clean 0x81 frame", s - base);
    end
    tests++;
    if (count(0, base, lg_n) !== 1 || count(1, base, lg_n) !== 1) begin
      fails++;
      $display("FAIL rst_counts: reads=%0d done=%0d want 1 1",
               count(0, base, lg_n), count(1, base, lg_n));
    end
  endtask

  task automatic test_reset_in_pop();
    @(negedge clk);
    en = 1'b1;
    push(8'h5A);
    repeat (2) @(negedge clk);
    #1;
    tests++;
    if (rd !== 1'b1) begin
      fails++;
      $display("FAIL pop_strobe: rd=%b want 1", rd);
    end
    #1 rst = 1'b1;
    #1;
    tests++;
    if (rd !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL pop_rst: rd=%b busy=%b want 0 0", rd, busy);
    end
    @(negedge clk);
    #2 rst = 1'b0;
    repeat (60) @(negedge clk);
  endtask

  task automatic test_random();
    int         base;
    int         n;
    int         nrx;
    int         prev;
    int         i;
    logic [7:0] r;
    logic [7:0] exp_b [16];
    logic [7:0] rx_b  [16];
    n = $urandom_range(4, 8);
    @(negedge clk);
    en   = 1'b1;
    base = lg_n;
    for (int j = 0; j < n; j++) begin
      repeat ($urandom_range(0, 50)) @(negedge clk);
      exp_b[j] = 8'($urandom);
      push(exp_b[j]);
    end
    repeat (n * (FRAME + 3) + 60) @(negedge clk);
    #1;
    nrx  = 0;
    prev = -1;
    i    = base;
    while (i + FRAME <= lg_n) begin
      if (lg_tx[i] === 1'b0) begin
        for (int k = 0; k < 8; k++) begin
          r[k] = lg_tx[i + CPB * (k + 1) + CPB / 2];
        end
        tests++;
        if (lg_tx[i + 9 * CPB + CPB / 2] !== 1'b1) begin
          fails++;
          $display("FAIL rand_stop: frame %0d stop=%b want 1", nrx,
                   lg_tx[i + 9 * CPB + CPB / 2]);
        end
        if (prev >= 0) begin
          tests++;
          if (i - prev < FRAME + 3) begin
            fails++;
            $display("FAIL rand_gap: start spacing %0d want >= %0d",
                     i - prev, FRAME + 3);
          end
        end
        if (nrx < 16) rx_b[nrx] = r;
        nrx++;
        prev = i;
        i    = i + FRAME;
      end else begin
        i++;
      end
    end
    tests++;
    if (nrx !== n || count(0, base, lg_n) !== n || count(1, base, lg_n) !== n) begin
      fails++;
      $display("FAIL rand_counts: frames=%0d reads=%0d done=%0d want %0d",
               nrx, count(0, base, lg_n), count(1, base, lg_n), n);
    end
    for (int j = 0; j < n && j < nrx; j++) begin
      tests++;
      if (rx_b[j] !== exp_b[j]) begin
        fails++;
        $display("FAIL rand_byte[%0d]: got %h want %h", j, rx_b[j], exp_b[j]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_empty();
    test_single();
    test_back_to_back();
    test_enable_gating();
    test_reset_midframe();
    test_reset_in_pop();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
